// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width/type, I2S receiver FSM states and
// output channel selectors.
package audio_pkg;

  localparam int unsigned SAMPLE_W_DEF = 16;

  typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } i2s_state_e;

  localparam int unsigned CH_LEFT  = 0;
  localparam int unsigned CH_RIGHT = 1;
  localparam int unsigned CH_MIX   = 2;

endpackage

// File: rtl/i2s_rx_if.sv
// Valid/ready sample hand-off from the I2S receiver to its consumer,
// plus the receiver's event pulses.
interface i2s_rx_if #(
  parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W_DEF
) ();

  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_valid;
  logic                       sample_ready;
  logic                       overrun;
  logic                       frame_err;

  modport master (
    output sample_out,
    output sample_valid,
    output overrun,
    output frame_err,
    input  sample_ready
  );

  modport slave (
    input  sample_out,
    input  sample_valid,
    input  overrun,
    input  frame_err,
    output sample_ready
  );

endinterface

// File: rtl/i2s_sync.sv
// Two-flop synchronizer for one asynchronous bit, with an optional
// rising-edge detect on the synchronized value.
module i2s_sync #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

  if (EDGE_EN) begin : g_edge
    logic s3_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s3_q <= 1'b0;
      else        s3_q <= s2_q;
    end
    assign rise = s2_q & ~s3_q;
  end else begin : g_no_edge
    assign rise = 1'b0;
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCLK, deserialises standard-I2S slots and hands one
// mono sample per frame to the consumer through a one-entry holding register.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
  parameter int unsigned SLOT_W      = 32,
  parameter int unsigned CHANNEL_SEL = CH_LEFT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     enable,
  input  logic     i2s_bclk,
  input  logic     i2s_lrclk,
  input  logic     i2s_sdata,
  i2s_rx_if.master out_if
);

  localparam int unsigned BW = $clog2(SAMPLE_W);
  localparam int unsigned SW = $clog2(SLOT_W + 1);

  logic [2:0] pins, pins_s, rise;
  logic       bit_tick, lr, sd, lr_change;

  assign pins = {i2s_sdata, i2s_lrclk, i2s_bclk};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    i2s_sync #(
      .EDGE_EN(i == 0)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (pins[i]),
      .q    (pins_s[i]),
      .rise (rise[i])
    );
  end

  // Only the BCLK lane has edge detection; the other rise bits are tied low.
  assign bit_tick = |(rise & pins_s);
  assign lr       = pins_s[1];
  assign sd       = pins_s[2];

  i2s_state_e           state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]        slot_cnt_q, slot_cnt_d;
  logic [SAMPLE_W-1:0]  shift_q, shift_d, word;
  logic [SAMPLE_W-1:0]  left_q, left_d, right_q, right_d;
  logic                 ch_q, ch_d, lr_last_q, primed_q, left_ok_q, left_ok_d;
  logic                 emit_q, emit_d, err_q, err_d;

  // The first tick after reset only learns LRCLK, so a slot in flight is never taken.
  assign lr_change = bit_tick && primed_q && (lr != lr_last_q);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    slot_cnt_d = slot_cnt_q;
    shift_d    = shift_q;
    ch_d       = ch_q;
    left_d     = left_q;
    right_d    = right_q;
    left_ok_d  = (state_q == IDLE) ? 1'b0 : left_ok_q;
    emit_d     = 1'b0;
    err_d      = 1'b0;
    word       = {shift_q[SAMPLE_W-2:0], sd};
    if (!enable) begin
      state_d   = IDLE;
      left_ok_d = 1'b0;
    end else if (lr_change) begin
      if (state_q == SHIFT) begin
        err_d     = 1'b1;
        left_ok_d = 1'b0;
      end
      state_d    = SHIFT;
      bit_cnt_d  = '0;
      slot_cnt_d = '0;
      ch_d       = lr;
    end else if (bit_tick && state_q != IDLE) begin
      if (slot_cnt_q == SW'(SLOT_W - 1)) begin
        err_d     = 1'b1;
        left_ok_d = 1'b0;
        state_d   = IDLE;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        if (state_q == SHIFT) begin
          shift_d   = word;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(SAMPLE_W - 1)) begin
            state_d = PAD;
            if (!ch_q) begin
              left_d    = word;
              left_ok_d = 1'b1;
              emit_d    = (CHANNEL_SEL == CH_LEFT);
            end else begin
              right_d = word;
              if (CHANNEL_SEL == CH_RIGHT) begin
                emit_d = 1'b1;
              end else if (CHANNEL_SEL == CH_MIX && left_ok_q) begin
                emit_d    = 1'b1;
                left_ok_d = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      slot_cnt_q <= '0;
      shift_q    <= '0;
      ch_q       <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      left_ok_q  <= 1'b0;
      lr_last_q  <= 1'b0;
      primed_q   <= 1'b0;
      emit_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      shift_q    <= shift_d;
      ch_q       <= ch_d;
      left_q     <= left_d;
      right_q    <= right_d;
      left_ok_q  <= left_ok_d;
      emit_q     <= emit_d;
      err_q      <= err_d;
      if (bit_tick) begin
        lr_last_q <= lr;
        primed_q  <= 1'b1;
      end
    end
  end

  logic signed [SAMPLE_W:0]   mix_sum;
  logic        [SAMPLE_W-1:0] emit_data, sample_q;
  logic                       valid_q, overrun_q;

  always_comb begin
    mix_sum = $signed({left_q[SAMPLE_W-1], left_q}) + $signed({right_q[SAMPLE_W-1], right_q});
    if (CHANNEL_SEL == CH_LEFT)       emit_data = left_q;
    else if (CHANNEL_SEL == CH_RIGHT) emit_data = right_q;
    else                              emit_data = mix_sum[SAMPLE_W:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (emit_q) begin
      sample_q  <= emit_data;
      valid_q   <= 1'b1;
      overrun_q <= valid_q && !out_if.sample_ready;
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && out_if.sample_ready) valid_q <= 1'b0;
    end
  end

  assign out_if.sample_out   = sample_q;
  assign out_if.sample_valid = valid_q;
  assign out_if.overrun      = overrun_q;
  assign out_if.frame_err    = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench: left, right and mix receivers share one I2S line; each
// step is checked against hand-computed values.
module tb_i2s_rx;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic i2s_bclk = 1'b0;
  logic i2s_lrclk = 1'b0;
  logic i2s_sdata = 1'b0;

  always #5 clk = ~clk;

  i2s_rx_if #(.SAMPLE_W(16)) if_l ();
  i2s_rx_if #(.SAMPLE_W(16)) if_r ();
  i2s_rx_if #(.SAMPLE_W(16)) if_m ();

  i2s_rx #(.SAMPLE_W(16), .SLOT_W(32), .CHANNEL_SEL(CH_LEFT)) u_l (
    .clk(clk), .rst_n(rst_n), .enable(enable), .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata), .out_if(if_l)
  );
  i2s_rx #(.SAMPLE_W(16), .SLOT_W(32), .CHANNEL_SEL(CH_RIGHT)) u_r (
    .clk(clk), .rst_n(rst_n), .enable(enable), .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata), .out_if(if_r)
  );
  i2s_rx #(.SAMPLE_W(16), .SLOT_W(32), .CHANNEL_SEL(CH_MIX)) u_m (
    .clk(clk), .rst_n(rst_n), .enable(enable), .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata), .out_if(if_m)
  );

  int          n_cmp, n_bad;
  int          hs_l, hs_m, ovr_l, err_l, h0, e0;
  logic [15:0] last_l, last_r, last_m;
  time         lsb_t, rise_l;
  logic        vprev_l = 1'b0;

  // Handshakes and pulses as seen at the clock edge that acts on them.
  always @(posedge clk) begin
    if (if_l.sample_valid && if_l.sample_ready) begin
      hs_l   <= hs_l + 1;
      last_l <= if_l.sample_out;
    end
    if (if_r.sample_valid && if_r.sample_ready) last_r <= if_r.sample_out;
    if (if_m.sample_valid && if_m.sample_ready) begin
      hs_m   <= hs_m + 1;
      last_m <= if_m.sample_out;
    end
    if (if_l.overrun)   ovr_l <= ovr_l + 1;
    if (if_l.frame_err) err_l <= err_l + 1;
  end

  always @(negedge clk) begin
    if (if_l.sample_valid && !vprev_l) rise_l <= $time;
    vprev_l <= if_l.sample_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One slot: bit 0 carries the previous LSB/pad, bits 1..16 the word MSB first.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int len,
                           input bit coincide);
    for (int k = 0; k < len; k++) begin
      i2s_bclk  = 1'b0;
      i2s_lrclk = lr;
      i2s_sdata = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
      repeat (4) @(negedge clk);
      i2s_bclk = 1'b1;
      if (k == 16 && !lr) lsb_t = $time;
      if (coincide && k == 16) begin
        repeat (3) @(negedge clk);
        if_l.sample_ready = 1'b1;
        @(negedge clk);
        check("coin_valid", {31'h0, if_l.sample_valid}, 32'h1);
        check("coin_sample", {16'h0, if_l.sample_out}, 32'h012C);
        check("coin_overrun", {31'h0, if_l.overrun}, 32'h0);
      end else begin
        repeat (4) @(negedge clk);
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 32, 1'b0);
    send_slot(1'b1, r, 32, 1'b0);
  endtask

  initial begin
    if_l.sample_ready = 1'b1;
    if_r.sample_ready = 1'b1;
    if_m.sample_ready = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_sample", {16'h0, if_l.sample_out}, 32'h0);
    check("rst_valid", {31'h0, if_l.sample_valid}, 32'h0);
    check("rst_overrun", {31'h0, if_l.overrun}, 32'h0);
    check("rst_frame_err", {31'h0, if_l.frame_err}, 32'h0);
    check("rst_mix_valid", {31'h0, if_m.sample_valid}, 32'h0);

    // Lead-in right slot gives the receivers an LRCLK edge to lock onto.
    send_slot(1'b1, 16'h0000, 32, 1'b0);
    send_slot(1'b0, 16'h7FFF, 32, 1'b0);
    check("latency", 32'(rise_l - lsb_t), 32'd40);
    send_slot(1'b1, 16'h1234, 32, 1'b0);
    send_frame(16'h7FFF, 16'h1234);
    check("left_count", hs_l, 32'd2);
    check("left_sample", {16'h0, last_l}, 32'h7FFF);
    check("right_sample", {16'h0, last_r}, 32'h1234);
    check("mix_7fff_1234", {16'h0, last_m}, 32'h4919);
    check("no_frame_err", err_l, 32'd0);

    send_frame(16'h8000, 16'h8001);
    check("mix_neg", {16'h0, last_m}, 32'h8000);
    send_frame(16'h0001, 16'h0000);
    check("mix_floor", {16'h0, last_m}, 32'h0000);
    check("mix_count", hs_m, 32'd4);

    if_l.sample_ready = 1'b0;
    send_frame(16'd100, 16'h0000);
    send_frame(16'd200, 16'h0000);
    check("bp_valid", {31'h0, if_l.sample_valid}, 32'h1);
    check("bp_sample", {16'h0, if_l.sample_out}, 32'd200);
    check("bp_overrun", ovr_l, 32'd1);
    send_slot(1'b0, 16'd300, 32, 1'b1);
    send_slot(1'b1, 16'h0000, 32, 1'b0);
    check("coin_consumed", {16'h0, last_l}, 32'd300);
    check("coin_ovr_count", ovr_l, 32'd1);

    h0 = hs_l;
    e0 = err_l;
    send_slot(1'b0, 16'hAAAA, 10, 1'b0);
    send_slot(1'b1, 16'hC3C3, 32, 1'b0);
    check("short_err", err_l, e0 + 1);
    check("short_no_emit", hs_l, h0);
    check("short_right", {16'h0, last_r}, 32'hC3C3);
    send_frame(16'h5A5A, 16'h0000);
    check("short_recover", {16'h0, last_l}, 32'h5A5A);
    check("short_count", hs_l, h0 + 1);

    e0 = err_l;
    send_slot(1'b0, 16'h1111, 32, 1'b0);
    check("long_before_32", err_l, e0);
    send_slot(1'b0, 16'h0000, 8, 1'b0);
    check("long_err", err_l, e0 + 1);
    send_slot(1'b1, 16'h7777, 32, 1'b0);
    send_frame(16'h2222, 16'h0000);
    check("long_err_once", err_l, e0 + 1);
    check("long_recover", {16'h0, last_l}, 32'h2222);

    if_l.sample_ready = 1'b0;
    send_frame(16'h4444, 16'h0000);
    check("pre_rst_valid", {31'h0, if_l.sample_valid}, 32'h1);
    send_slot(1'b0, 16'hBEEF, 8, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'h0, if_l.sample_valid}, 32'h0);
    check("midrst_sample", {16'h0, if_l.sample_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_slot(1'b0, 16'h0000, 24, 1'b0);
    send_slot(1'b1, 16'h0BAD, 32, 1'b0);
    check("postrst_no_emit", {31'h0, if_l.sample_valid}, 32'h0);
    check("postrst_right", {16'h0, last_r}, 32'h0BAD);
    send_frame(16'h6666, 16'h0000);
    check("postrst_valid", {31'h0, if_l.sample_valid}, 32'h1);
    check("postrst_sample", {16'h0, if_l.sample_out}, 32'h6666);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S receiver that deserialises trumpet audio from the codec ADC and presents one signed 16-bit mono sample per audio frame to `audio_processor`'s `in_sample` input. It is the stage directly upstream of `audio_processor`. In hardware it replaces the file-driven sample feed used in simulation. It oversamples the I2S bit clock with the system clock and hands each sample off through a one-entry valid/ready holding register.

## Interface
- `SAMPLE_W`, 16: captured bits per channel, MSB first; equals the `in_sample` width.
- `SLOT_W`, 32: maximum BCLK cycles per channel slot before a framing error is flagged.
- `CHANNEL_SEL`, 0: selects the output source. 0 = left, 1 = right, 2 = mix (L+R)>>>1.

- `clk`  in  1  system clock; must be at least 8× the BCLK frequency (e.g. 100 MHz vs 3.072 MHz).
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock; all state is reset by `rst_n`.
- `enable`  in  1  receiver enable; low drops any in-progress capture.
- `i2s_bclk`  in  1  codec bit clock, asynchronous to `clk`.
- `i2s_lrclk`  in  1  word select, asynchronous; low = left, high = right.
- `i2s_sdata`  in  1  serial data, asynchronous.
- `sample_out`  out  SAMPLE_W  signed sample, held stable while `sample_valid` is high.
- `sample_valid`  out  1  holding register is full.
- `sample_ready`  in  1  the consumer takes the sample at a clk edge when valid && ready.
- `overrun`  out  1  one-cycle pulse: an unconsumed sample was overwritten.
- `frame_err`  out  1  one-cycle pulse: a slot was too short or too long.

## Operation
- **Synchronisation.** `i2s_bclk`, `i2s_lrclk` and `i2s_sdata` each pass through a 2-FF synchronizer. A third BCLK register detects the rising edge. All protocol actions occur only on a detected BCLK rising edge (`bit_tick`).
- **Standard I2S timing.** The MSB is sampled on the second BCLK rising edge after an LRCLK transition. The first edge after a transition carries the previous slot's LSB or pad bit and is ignored.
- **FSM states: IDLE, SHIFT, PAD.**
  - IDLE: wait for an LRCLK change at a `bit_tick`. On a change, go to SHIFT, clear `bit_cnt` and `slot_cnt`, and latch the channel from LRCLK. Frames that were partially in progress at reset or enable are discarded.
  - SHIFT: on each `bit_tick`, shift `sdata` into the shift register. When `bit_cnt == SAMPLE_W-1`, store the completed word to the left or right word register and go to PAD.
  - PAD: ignore bits. An LRCLK change starts a new slot and returns to SHIFT.
- **Framing errors.**
  - An LRCLK change while in SHIFT pulses `frame_err`, discards the partial word, and restarts SHIFT for the new channel.
  - `slot_cnt` reaching SLOT_W without an LRCLK change pulses `frame_err` and returns to IDLE.
- **Emission by `CHANNEL_SEL`.**
  - 0: emit when the left word completes.
  - 1: emit when the right word completes.
  - 2: emit when the right word completes and `left_ok` is set. `left_ok` is set by left-word completion and cleared by emission, by any `frame_err`, and by IDLE. The result is a 17-bit signed sum arithmetically shifted right by 1 (floor), taking the low SAMPLE_W bits; it never overflows.
- **Holding register.**
  - An emission loads `sample_out` and sets `sample_valid`.
  - valid && ready with no emission in the same cycle clears valid.
  - If an emission arrives while valid && !ready, new data replaces old and `overrun` pulses.
  - If an emission arrives with valid && ready in the same cycle, the old sample is consumed, the new one is loaded, valid stays 1, and there is no overrun.
- **`enable` low.** The FSM is forced to IDLE and `left_ok` is cleared. The holding register and handshake keep operating, so a pending sample can still be drained.

## Timing
- **Reset values.** `sample_out`=0, `sample_valid`=0, `overrun`=0, `frame_err`=0, FSM=IDLE, `bit_cnt`=`slot_cnt`=0, all synchronizer flops=0, `left_ok`=0.
- **Latency.** `sample_valid` rises exactly 4 clk cycles after the clk edge at which `i2s_bclk` rises with the final captured bit present on the pin: 2 synchronizer stages + 1 edge-detect/shift + 1 output register.
- **Pulse widths.** `overrun` and `frame_err` are registered one-cycle pulses, aligned with the cycle the condition is acted on.
- **Reset mid-frame.** Takes effect asynchronously. After `rst_n` release, the first emitted sample comes from the first complete slot that follows an observed LRCLK edge.

## Structure
- Shared `audio_pkg` holds:
  - `SAMPLE_W_DEF` (16) and a `sample_t` typedef.
  - The `i2s_state_e` enum (IDLE/SHIFT/PAD).
  - The `CH_LEFT`/`CH_RIGHT`/`CH_MIX` constants.
- One sub-module, `i2s_sync`: a per-bit 2-FF synchronizer plus an optional rising-edge detect output. It is instantiated three times.

## Test plan
- **Reset and idle.** Reset, then idle BCLK: all outputs are 0. Reset asserted mid-SHIFT: outputs clear immediately, and no sample is emitted until a new full slot arrives.
- **Left channel.** CHANNEL_SEL=0, 64-BCLK frames, L=16'h7FFF, R=16'h1234, ready held 1: `sample_out`=16'h7FFF with one valid pulse per frame, 4 clk after the L LSB edge.
- **Mix mode.** CHANNEL_SEL=2, L=16'h8000, R=16'h8001: output 16'h8000. L=16'h0001, R=16'h0000: output 16'h0000 (floor).
- **Backpressure.** `sample_ready`=0 for two frames with L=100 then L=200: `sample_out`=200, `overrun` pulses once. Emission coinciding with ready=1: valid stays high, no overrun.
- **Short slot.** LRCLK toggles after 10 bits in a slot: one `frame_err` pulse, no emission for that slot, and the next full slot is captured correctly.
- **Long slot.** LRCLK held for 40 BCLKs: one `frame_err` pulse at BCLK 32, the FSM returns to IDLE, and normal framing resumes after the next LRCLK edge.
